// File: rtl/xadac_pkg.sv
// Shared xadac types and widths used by the vector memory port.
package xadac_pkg;
  localparam int IdWidth      = 4;
  localparam int AddrWidth    = 32;
  localparam int VecDataWidth = 128;
  localparam int VecStrbWidth = VecDataWidth / 8;
  localparam int VecByteOffW  = $clog2(VecStrbWidth);

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [AddrWidth-1:0]    AddrT;
  typedef logic [VecDataWidth-1:0] VecDataT;
  typedef logic [VecStrbWidth-1:0] VecStrbT;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} vec_wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} vec_rd_state_e;
  typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} vec_prio_e;

  typedef struct packed {
    IdT      id;
    VecDataT data;
    VecStrbT strb;
  } vec_wr_req_t;

  // Word number relative to the window base; caller truncates to the RAM index.
  function automatic AddrT vec_word_of(AddrT addr, AddrT base);
    return (addr - base) >> VecByteOffW;
  endfunction
endpackage

// File: rtl/xadac_vec_mem_sram.sv
// Single-port RAM, one byte-wide bank per lane, 1-cycle synchronous read.
module xadac_vec_mem_sram #(
  parameter int Depth = 1024,
  parameter int Width = 128,
  localparam int AddrW    = $clog2(Depth),
  localparam int NumBytes = Width / 8
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [AddrW-1:0]    addr,
  input  logic [NumBytes-1:0] be,
  input  logic [Width-1:0]    wdata,
  output logic [Width-1:0]    rdata
);
  for (genvar b = 0; b < NumBytes; b++) begin : g_lane
    logic [7:0] mem [Depth];
    logic [7:0] rd_q;

    // Read data only updates on a read, so it holds across later writes.
    always_ff @(posedge clk) begin
      if (en && we && be[b]) mem[addr] <= wdata[b*8 +: 8];
      if (en && !we)         rd_q      <= mem[addr];
    end

    assign rdata[b*8 +: 8] = rd_q;
  end
endmodule

// File: rtl/xadac_vec_mem.sv
// Single-beat AXI subordinate memory for the xadac vector load/store port.
// Define XADAC_VEC_MEM_TRACE_EN to print every RAM commit in simulation.
module xadac_vec_mem
  import xadac_pkg::*;
#(
  parameter int   Depth    = 1024,
  parameter AddrT BaseAddr = '0
) (
  input  logic    clk,
  input  logic    rst,
  input  IdT      axi_aw_id,
  input  AddrT    axi_aw_addr,
  input  logic    axi_aw_valid,
  output logic    axi_aw_ready,
  input  VecDataT axi_w_data,
  input  VecStrbT axi_w_strb,
  input  logic    axi_w_valid,
  output logic    axi_w_ready,
  output IdT      axi_b_id,
  output logic    axi_b_valid,
  input  logic    axi_b_ready,
  input  IdT      axi_ar_id,
  input  AddrT    axi_ar_addr,
  input  logic    axi_ar_valid,
  output logic    axi_ar_ready,
  output IdT      axi_r_id,
  output VecDataT axi_r_data,
  output logic    axi_r_valid,
  input  logic    axi_r_ready
);
  localparam int IdxW = $clog2(Depth);
  typedef logic [IdxW-1:0] idx_t;

  // write path state
  vec_wr_state_e w_state_q, w_state_d;
  vec_wr_req_t   wr_q, wr_d;
  idx_t          wr_idx_q, wr_idx_d;
  logic          aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic          aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic          b_valid_q, b_valid_d;
  IdT            b_id_q, b_id_d;

  // read path state
  vec_rd_state_e r_state_q, r_state_d;
  IdT            rd_id_q, rd_id_d;
  idx_t          rd_idx_q, rd_idx_d;
  logic          ar_ready_q, ar_ready_d;
  logic          r_valid_q, r_valid_d;
  IdT            r_id_q, r_id_d;

  vec_prio_e prio_q, prio_d;
  logic      wr_req, rd_req, wr_gnt, rd_gnt;
  logic      aw_hs, w_hs, ar_hs;
  VecDataT   ram_rdata;

  assign aw_hs = axi_aw_valid & aw_ready_q;
  assign w_hs  = axi_w_valid  & w_ready_q;
  assign ar_hs = axi_ar_valid & ar_ready_q;

  // Arbiter: on a conflict the priority bit picks, then hands priority to the loser.
  assign wr_req = (w_state_q == W_COMMIT);
  assign rd_req = (r_state_q == R_ACCESS);
  assign wr_gnt = wr_req & (~rd_req | (prio_q == PRIO_WR));
  assign rd_gnt = rd_req & (~wr_req | (prio_q == PRIO_RD));

  always_comb begin
    prio_d = prio_q;
    if (wr_req && rd_req) prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
  end

  always_comb begin
    w_state_d  = w_state_q;
    wr_d       = wr_q;
    wr_idx_d   = wr_idx_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_id_d     = b_id_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          wr_d.id  = axi_aw_id;
          wr_idx_d = idx_t'(vec_word_of(axi_aw_addr, BaseAddr));
          aw_got_d = 1'b1;
        end
        if (w_hs) begin
          wr_d.data = axi_w_data;
          wr_d.strb = axi_w_strb;
          w_got_d   = 1'b1;
        end
        // Each ready stays up until its own channel has been captured.
        aw_ready_d = ~aw_got_d;
        w_ready_d  = ~w_got_d;
        if (aw_got_d && w_got_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        if (wr_gnt) begin
          w_state_d = W_RESP;
          b_valid_d = 1'b1;
          b_id_d    = wr_q.id;
        end
      end
      W_RESP: begin
        if (axi_b_ready) begin
          w_state_d  = W_IDLE;
          b_valid_d  = 1'b0;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    rd_id_d    = rd_id_q;
    rd_idx_d   = rd_idx_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_id_d     = r_id_q;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ar_hs) begin
          rd_id_d    = axi_ar_id;
          rd_idx_d   = idx_t'(vec_word_of(axi_ar_addr, BaseAddr));
          ar_ready_d = 1'b0;
          r_state_d  = R_ACCESS;
        end
      end
      R_ACCESS: begin
        if (rd_gnt) begin
          r_state_d = R_RESP;
          r_valid_d = 1'b1;
          r_id_d    = rd_id_q;
        end
      end
      R_RESP: begin
        if (axi_r_ready) begin
          r_state_d  = R_IDLE;
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      wr_q       <= '0;
      wr_idx_q   <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      r_state_q  <= R_IDLE;
      rd_id_q    <= '0;
      rd_idx_q   <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      prio_q     <= PRIO_WR;
    end else begin
      w_state_q  <= w_state_d;
      wr_q       <= wr_d;
      wr_idx_q   <= wr_idx_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      r_state_q  <= r_state_d;
      rd_id_q    <= rd_id_d;
      rd_idx_q   <= rd_idx_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_id_q     <= r_id_d;
      prio_q     <= prio_d;
    end
  end

  xadac_vec_mem_sram #(
    .Depth (Depth),
    .Width (VecDataWidth)
  ) u_sram (
    .clk   (clk),
    .en    (wr_gnt | rd_gnt),
    .we    (wr_gnt),
    .addr  (wr_gnt ? wr_idx_q : rd_idx_q),
    .be    (wr_q.strb),
    .wdata (wr_q.data),
    .rdata (ram_rdata)
  );

  assign axi_aw_ready = aw_ready_q;
  assign axi_w_ready  = w_ready_q;
  assign axi_b_valid  = b_valid_q;
  assign axi_b_id     = b_id_q;
  assign axi_ar_ready = ar_ready_q;
  assign axi_r_valid  = r_valid_q;
  assign axi_r_id     = r_id_q;
  // RAM output is not reset; gate it so r_data is zero outside a response.
  assign axi_r_data   = r_valid_q ? ram_rdata : '0;

`ifdef XADAC_VEC_MEM_TRACE_EN
  logic rd_trace_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_trace_q <= 1'b0;
    else     rd_trace_q <= rd_gnt;
  end

  always @(posedge clk) begin
    if (!rst && wr_gnt)
      $display("%0t vec_mem W id=%h idx=%h strb=%h data=%h", $time, wr_q.id, wr_idx_q, wr_q.strb, wr_q.data);
    if (!rst && rd_trace_q)
      $display("%0t vec_mem R id=%h idx=%h data=%h", $time, r_id_q, rd_idx_q, ram_rdata);
  end
`endif
endmodule

// File: tb/tb_xadac_vec_mem.sv
// Scoreboarded random + directed bench for xadac_vec_mem against a word-array model.
module tb_xadac_vec_mem;
  import xadac_pkg::*;

  localparam int   DEPTH = 1024;
  localparam AddrT BASE  = 32'h1000_0000;

  logic    clk = 1'b0;
  logic    rst;
  IdT      aw_id, ar_id, b_id, r_id;
  AddrT    aw_addr, ar_addr;
  logic    aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic    ar_valid, ar_ready, r_valid, r_ready;
  VecDataT w_data, r_data;
  VecStrbT w_strb;

  xadac_vec_mem #(.Depth(DEPTH), .BaseAddr(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
    .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_valid(w_valid), .axi_w_ready(w_ready),
    .axi_b_id(b_id), .axi_b_valid(b_valid), .axi_b_ready(b_ready),
    .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
    .axi_r_id(r_id), .axi_r_data(r_data), .axi_r_valid(r_valid), .axi_r_ready(r_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { IdT id; VecDataT data; } exp_r_t;
  IdT      exp_b[$];
  exp_r_t  exp_r[$];
  VecDataT mem_m [int];
  int      total = 0;
  int      bad = 0;
  bit      rand_bp = 0;

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void flag(string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endfunction

  function automatic int idx_of(AddrT a);
    AddrT off = a - BASE;
    return int'((off / VecStrbWidth) % DEPTH);
  endfunction

  function automatic VecDataT rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_bp) begin
      b_ready = ($urandom_range(0, 3) != 0);
      r_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drive_aw(IdT id, AddrT a);
    aw_id = id; aw_addr = a; aw_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (aw_ready) begin cyc(); aw_valid = 1'b0; return; end
      cyc();
    end
    aw_valid = 1'b0;
    flag("aw handshake timeout");
  endtask

  task automatic drive_w(VecDataT d, VecStrbT s);
    w_data = d; w_strb = s; w_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (w_ready) begin cyc(); w_valid = 1'b0; return; end
      cyc();
    end
    w_valid = 1'b0;
    flag("w handshake timeout");
  endtask

  task automatic drive_ar(IdT id, AddrT a);
    ar_id = id; ar_addr = a; ar_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (ar_ready) begin cyc(); ar_valid = 1'b0; return; end
      cyc();
    end
    ar_valid = 1'b0;
    flag("ar handshake timeout");
  endtask

  task automatic do_write(IdT id, AddrT a, VecDataT d, VecStrbT s);
    int i = idx_of(a);
    VecDataT nw = mem_m.exists(i) ? mem_m[i] : '0;
    for (int b = 0; b < VecStrbWidth; b++)
      if (s[b]) nw[b*8 +: 8] = d[b*8 +: 8];
    mem_m[i] = nw;
    exp_b.push_back(id);
    fork
      drive_aw(id, a);
      drive_w(d, s);
    join
  endtask

  task automatic do_read(IdT id, AddrT a);
    exp_r.push_back('{id: id, data: mem_m[idx_of(a)]});
    drive_ar(id, a);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0) begin cyc(); return; end
      cyc();
    end
    flag("drain timeout");
    exp_b.delete();
    exp_r.delete();
  endtask

  task automatic wait_r_valid();
    for (int k = 0; k < 50; k++) begin
      if (r_valid) return;
      cyc();
    end
    flag("r_valid timeout");
  endtask

  task automatic wait_b_valid();
    for (int k = 0; k < 50; k++) begin
      if (b_valid) return;
      cyc();
    end
    flag("b_valid timeout");
  endtask

  // Pops the scoreboard on every handshake and checks held responses stay stable.
  task automatic monitor();
    bit      bh = 0, rh = 0;
    IdT      bid_h = '0, rid_h = '0;
    VecDataT rdat_h = '0;
    forever begin
      @(negedge clk);
      if (rst) begin bh = 0; rh = 0; continue; end
      if (bh) begin
        if (!b_valid) flag("b_valid dropped without b_ready");
        else check("b_id stable", b_id, bid_h);
      end
      if (rh) begin
        if (!r_valid) flag("r_valid dropped without r_ready");
        else begin
          check("r_id stable", r_id, rid_h);
          check("r_data stable", r_data, rdat_h);
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) flag("unexpected B");
        else check("b_id", b_id, exp_b.pop_front());
      end
      if (r_valid && r_ready) begin
        if (exp_r.size() == 0) flag("unexpected R");
        else begin
          exp_r_t e = exp_r.pop_front();
          check("r_id", r_id, e.id);
          check("r_data", r_data, e.data);
        end
      end
      bh = b_valid && !b_ready; bid_h = b_id;
      rh = r_valid && !r_ready; rid_h = r_id; rdat_h = r_data;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    VecDataT d, new1, new2;
    rst = 1'b1;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    aw_id = '0; aw_addr = '0; w_data = '0; w_strb = '0; ar_id = '0; ar_addr = '0;
    b_ready = 1'b1; r_ready = 1'b1;
    fork monitor(); join_none

    // reset state
    repeat (3) cyc();
    check("rst aw_ready", aw_ready, 0);
    check("rst w_ready", w_ready, 0);
    check("rst ar_ready", ar_ready, 0);
    check("rst b_valid", b_valid, 0);
    check("rst r_valid", r_valid, 0);
    check("rst b_id", b_id, 0);
    check("rst r_id", r_id, 0);
    check("rst r_data", r_data, 0);
    rst = 1'b0;
    cyc();
    check("post-rst aw_ready", aw_ready, 1);
    check("post-rst ar_ready", ar_ready, 1);

    // 1: write then read at BASE+0x40, exact latencies
    d = {16{8'hAA}};
    mem_m[idx_of(BASE + 32'h40)] = d;
    exp_b.push_back(4'd3);
    aw_id = 4'd3; aw_addr = BASE + 32'h40; aw_valid = 1;
    w_data = d; w_strb = '1; w_valid = 1;
    cyc();
    aw_valid = 0; w_valid = 0;
    check("t1 b_valid t+1", b_valid, 0);
    check("t1 aw_ready busy", aw_ready, 0);
    cyc();
    check("t1 b_valid t+2", b_valid, 1);
    check("t1 b_id t+2", b_id, 3);
    drain();
    exp_r.push_back('{id: 4'd5, data: d});
    ar_id = 4'd5; ar_addr = BASE + 32'h40; ar_valid = 1;
    cyc();
    ar_valid = 0;
    check("t1 r_valid t+1", r_valid, 0);
    cyc();
    check("t1 r_valid t+2", r_valid, 1);
    drain();

    // 2: W four cycles ahead of AW, partial strobe over all-0xFF
    do_write(4'd1, BASE + 32'h80, {16{8'hFF}}, '1);
    drain();
    d = rnd_data();
    mem_m[idx_of(BASE + 32'h80)] = {{12{8'hFF}}, d[31:0]};
    exp_b.push_back(4'd2);
    drive_w(d, 16'h000F);
    for (int k = 0; k < 4; k++) begin
      check("t2 no B before AW", b_valid, 0);
      check("t2 w_ready held low", w_ready, 0);
      cyc();
    end
    drive_aw(4'd2, BASE + 32'h80 + 32'h7);
    drain();
    do_read(4'd6, BASE + 32'h80);
    drain();

    // 3: R backpressure while a concurrent write completes
    r_ready = 1'b0;
    fork
      do_read(4'd7, BASE + 32'h40);
      do_write(4'd8, BASE + 32'h70, rnd_data(), '1);
    join
    wait_r_valid();
    for (int k = 0; k < 20 && exp_b.size() != 0; k++) cyc();
    check("t3 write done under R stall", exp_b.size(), 0);
    for (int k = 0; k < 10; k++) begin
      check("t3 ar_ready stalled", ar_ready, 0);
      check("t3 r_valid held", r_valid, 1);
      cyc();
    end
    r_ready = 1'b1;
    drain();

    // 5a: reset while B is pending
    b_ready = 1'b0;
    do_write(4'd9, BASE + 32'h90, rnd_data(), '1);
    wait_b_valid();
    rst = 1'b1;
    #1;
    check("t5 b_valid drops in reset", b_valid, 0);
    check("t5 aw_ready in reset", aw_ready, 0);
    exp_b.delete();
    cyc();
    rst = 1'b0;
    b_ready = 1'b1;
    cyc();
    check("t5 aw_ready after release", aw_ready, 1);
    check("t5 w_ready after release", w_ready, 1);
    check("t5 ar_ready after release", ar_ready, 1);
    // 5b: reset during the read access cycle
    drive_ar(4'd4, BASE + 32'h40);
    rst = 1'b1;
    #1;
    check("t5 r_valid in reset", r_valid, 0);
    check("t5 ar_ready in reset", ar_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    check("t5 ar_ready after release 2", ar_ready, 1);
    for (int k = 0; k < 5; k++) begin
      check("t5 no stale B", b_valid, 0);
      check("t5 no stale R", r_valid, 0);
      cyc();
    end

    // 4: two same-index conflicts; priority starts at write then alternates
    new1 = rnd_data();
    new2 = rnd_data();
    mem_m[idx_of(BASE + 32'hC0)] = new1;
    exp_b.push_back(4'hA);
    exp_r.push_back('{id: 4'hB, data: new1});
    fork
      drive_aw(4'hA, BASE + 32'hC0);
      drive_w(new1, '1);
      drive_ar(4'hB, BASE + 32'hC0);
    join
    cyc();
    check("t4 c1 write first b_valid", b_valid, 1);
    check("t4 c1 read waits", r_valid, 0);
    cyc();
    check("t4 c1 read after", r_valid, 1);
    drain();
    mem_m[idx_of(BASE + 32'hC0)] = new2;
    exp_b.push_back(4'hC);
    exp_r.push_back('{id: 4'hD, data: new1});
    fork
      drive_aw(4'hC, BASE + 32'hC0);
      drive_w(new2, '1);
      drive_ar(4'hD, BASE + 32'hC0);
    join
    cyc();
    check("t4 c2 read first r_valid", r_valid, 1);
    check("t4 c2 write waits", b_valid, 0);
    drain();
    do_read(4'hE, BASE + 32'hC0);
    drain();

    // 6: one window past the end aliases word 0
    do_write(4'h1, BASE, rnd_data(), '1);
    drain();
    do_read(4'h2, BASE + 32'(DEPTH * VecStrbWidth));
    drain();

    // random phase over 16 words with aliased/sub-word addresses and backpressure
    for (int i = 0; i < 16; i++) do_write(IdT'(i), BASE + 32'(i * VecStrbWidth), rnd_data(), '1);
    drain();
    rand_bp = 1;
    for (int it = 0; it < 150; it++) begin
      int   op = $urandom_range(0, 2);
      int   i1 = $urandom_range(0, 15);
      int   i2 = (i1 + 1 + $urandom_range(0, 14)) % 16;
      AddrT a1 = BASE + 32'(i1 * VecStrbWidth + $urandom_range(0, 2) * DEPTH * VecStrbWidth + $urandom_range(0, 15));
      AddrT a2 = BASE + 32'(i2 * VecStrbWidth + $urandom_range(0, 2) * DEPTH * VecStrbWidth + $urandom_range(0, 15));
      case (op)
        0: do_write(IdT'($urandom), a1, rnd_data(), VecStrbT'($urandom));
        1: do_read(IdT'($urandom), a1);
        default: fork
          do_write(IdT'($urandom), a1, rnd_data(), VecStrbT'($urandom));
          do_read(IdT'($urandom), a2);
        join
      endcase
      drain();
    end
    rand_bp = 0;
    b_ready = 1; r_ready = 1;
    for (int i = 0; i < 16; i++) do_read(IdT'(i), BASE + 32'(i * VecStrbWidth));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
